ntt_twiddle_seq: RTL
====================

Name: ntt_twiddle_seq

Overview:
- Parametrised twiddle-factor sequencer for the NTT/INTT datapath.
- Holds an elaboration-time zeta table, zeta[k] = ROOT^bitrev(k) mod Q for k in [0, N/2).
- On start, streams one token per butterfly group over a valid/ready handshake. Forward mode walks k ascending; inverse mode walks k descending.
- Feeds the butterfly controller. Each token carries the zeta, k, group length and a last flag.

Parameters:
- Q, 3329, prime modulus.
- QW, 12, coefficient/zeta width; must satisfy 2^QW > Q.
- LOG_N, 8, log2 of polynomial length N. Token index width is LOG_N-1.
- ROOT, 17, primitive N-th root of unity mod Q.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; ignored unless idle.
- mode  in  1  0 = forward (k = 1..N/2-1), 1 = inverse (k = N/2-1..1); sampled only with an accepted start.
- abort  in  1  synchronous cancel of the current pass.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  single-cycle pulse after the last token handshakes.
- tw_valid  out  1  token valid.
- tw_ready  in  1  consumer ready.
- tw_zeta  out  QW  zeta[k], in [0, Q-1].
- tw_k  out  LOG_N-1  table index k.
- tw_len_log2  out  $clog2(LOG_N)  log2 of butterfly half-length, = LOG_N-1-floor(log2 k).
- tw_last  out  1  high on the final token of a pass.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counter 0; latched mode 0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches mode and loads k (1 for forward, N/2-1 for inverse).
  - Goes to RUN. The first token is registered, so tw_valid=1 one cycle after start.
- RUN:
  - The output register loads the next token when !tw_valid || tw_ready (registered-output pipeline, throughput 1 token/cycle).
  - tw_* are held stable while tw_valid && !tw_ready.
  - k increments (forward) or decrements (inverse) on each load.
  - tw_last=1 when the loaded k is N/2-1 (forward) or 1 (inverse).
  - When the last token handshakes, tw_valid drops and the FSM goes to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Timing with tw_ready tied high: start at cycle t; tokens on t+1 .. t+N/2-1; done at t+N/2. For N=256, done is at t+128.
- Boundary cases:
  - start while busy or in FIN: ignored.
  - start and abort together in IDLE: abort wins; stay IDLE.
  - abort in RUN: next cycle tw_valid=0, busy=0, FIN skipped, no done pulse, FSM in IDLE.
  - mode changes mid-pass: no effect.
  - k never wraps; k=0 is never emitted.
  - Asynchronous rst mid-pass: all outputs cleared immediately; no done pulse.
- Arithmetic:
  - Table built by constant functions: bit-reverse over LOG_N-1 bits, then square-and-multiply mod Q.
  - Intermediate products use a width of at least 2*QW.
  - Table output is registered; nothing is computed at run time.

Optional Feature:
- Macro: NTT_TW_MONT_EN.
- Defined: the table stores zeta*R mod Q, with R = 2^16 mod Q (Montgomery domain, feeding a Montgomery-reduction butterfly). For Q=3329: zeta[1]=2571, zeta[64]=2226.
- Undefined: plain zetas (zeta[1]=1729, zeta[64]=17).
- Sequencing and timing are identical in both builds.

Decomposition:
- Package ntt_pkg:
  - Q, QW, LOG_N defaults.
  - Mode encoding constants NTT_FWD=0, NTT_INV=1.
  - Constant functions bitrev() and modpow().
  - Montgomery R constant.
- One sub-module: ntt_tw_rom.
  - Parametrised N/2 x QW table with a synchronous registered read.
  - Built from ntt_pkg functions; honours NTT_TW_MONT_EN.
- The sequencer FSM and handshake stay in ntt_twiddle_seq.

Test Plan:
- Forward, tw_ready=1, start at t:
  - t+1: zeta=1729, k=1, len_log2=7.
  - t+2: zeta=2580, k=2, len_log2=6.
  - t+127: zeta=2154, k=127, len_log2=1, last=1.
  - done at t+128; 127 tokens total.
- Inverse, tw_ready=1:
  - First token: k=127, zeta=2154, len_log2=1.
  - Second token: k=126, zeta=885.
  - Final token: k=1, zeta=1729, len_log2=7, last=1.
  - done one cycle after the final handshake.
- Backpressure in forward: tw_ready=0 for 5 cycles while the k=3 token is presented -> zeta=3289 and k=3 held stable; the next accepted token is k=4 (2642); no token is lost or duplicated.
- Control during a pass:
  - start pulsed mid-pass with mode flipped -> ignored; the sequence is unchanged.
  - abort at k=40 -> tw_valid=0 and busy=0 next cycle; no done; a fresh start restarts at k=1.
- Asynchronous rst asserted mid-pass, between clock edges -> all outputs 0 immediately; after release, idle until start.
- NTT_TW_MONT_EN build: forward pass -> first token zeta=2571; k=64 token zeta=2226.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and elaboration-time helpers for the NTT twiddle path.
//   - Default modulus/width/length parameters and the primitive root.
//   - Mode encoding (NTT_FWD / NTT_INV) and the sequencer state type.
//   - Constant functions bitrev(), modpow(), flog2(), mont_r() used to build the zeta table.
package ntt_pkg;

    localparam int unsigned NTT_Q     = 3329;
    localparam int unsigned NTT_QW    = 12;
    localparam int unsigned NTT_LOG_N = 8;
    localparam int unsigned NTT_ROOT  = 17;

    localparam logic NTT_FWD = 1'b0;
    localparam logic NTT_INV = 1'b1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} seq_state_e;

    // Reverse the low 'bits' bits of v.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

    // base^exp mod q by square-and-multiply; 64-bit intermediates cover any 32-bit q.
    function automatic logic [63:0] modpow(input logic [63:0] base, input logic [63:0] exp,
                                           input logic [63:0] q);
        logic [63:0] r;
        logic [63:0] b;
        logic [63:0] e;
        r = 64'd1 % q;
        b = base % q;
        e = exp;
        for (int i = 0; i < 64; i++) begin
            if (e[0]) r = (r * b) % q;
            b = (b * b) % q;
            e = e >> 1;
        end
        return r;
    endfunction

    // floor(log2 v) for v > 0; 0 for v == 0.
    function automatic int unsigned flog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Montgomery radix R = 2^16 reduced mod q.
    function automatic logic [63:0] mont_r(input logic [63:0] q);
        return 64'h1_0000 % q;
    endfunction

    localparam logic [63:0] NTT_MONT_R = mont_r(64'(NTT_Q));

endpackage

// File: rtl/ntt_tw_rom.sv
// ntt_tw_rom: N/2 x QW zeta table, zeta[k] = ROOT^bitrev(k) mod Q, with a registered read.
//   Build option NTT_TW_MONT_EN: entries stored as zeta*R mod Q (R = 2^16 mod Q).
//   clk, rst : clock, async active-high reset (clears the read register)
//   en_i     : load the read register from addr_i
//   addr_i   : table index k
//   data_o   : registered table entry
module ntt_tw_rom
    import ntt_pkg::*;
#(
    parameter int unsigned Q     = NTT_Q,
    parameter int unsigned QW    = NTT_QW,
    parameter int unsigned LOG_N = NTT_LOG_N,
    parameter int unsigned ROOT  = NTT_ROOT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [LOG_N-2:0] addr_i,
    output logic [QW-1:0]    data_o
);

    localparam int unsigned Half = 32'd1 << (LOG_N - 1);

    function automatic logic [QW-1:0] entry(input int unsigned k);
        logic [63:0] z;
        z = modpow(64'(ROOT), 64'(bitrev(k, LOG_N - 1)), 64'(Q));
`ifdef NTT_TW_MONT_EN
        z = (z * mont_r(64'(Q))) % 64'(Q);
`endif
        return z[QW-1:0];
    endfunction

    logic [QW-1:0] rom [Half];

    for (genvar i = 0; i < Half; i++) begin : g_rom
        assign rom[i] = entry(i);
    end

    logic [QW-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ntt_twiddle_seq.sv
// ntt_twiddle_seq: streams one twiddle token per butterfly group over valid/ready.
//   Forward walks k = 1 .. N/2-1, inverse walks k = N/2-1 .. 1.
//   Build option NTT_TW_MONT_EN (via ntt_tw_rom): Montgomery-domain zetas.
//   clk, rst      : clock, async active-high reset
//   start_i       : begin a pass (idle only); mode_i sampled with it (0 fwd, 1 inv)
//   abort_i       : synchronous cancel, no done pulse
//   busy_o        : pass in progress
//   done_o        : one-cycle pulse after the last token handshakes
//   tw_valid_o / tw_ready_i : token handshake
//   tw_zeta_o, tw_k_o, tw_len_log2_o, tw_last_o : token fields
module ntt_twiddle_seq
    import ntt_pkg::*;
#(
    parameter int unsigned Q     = NTT_Q,
    parameter int unsigned QW    = NTT_QW,
    parameter int unsigned LOG_N = NTT_LOG_N,
    parameter int unsigned ROOT  = NTT_ROOT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       tw_valid_o,
    input  logic                       tw_ready_i,
    output logic [QW-1:0]              tw_zeta_o,
    output logic [LOG_N-2:0]           tw_k_o,
    output logic [$clog2(LOG_N)-1:0]   tw_len_log2_o,
    output logic                       tw_last_o
);

    localparam int unsigned KW   = LOG_N - 1;
    localparam int unsigned LW   = $clog2(LOG_N);
    localparam int unsigned Half = 32'd1 << (LOG_N - 1);

    seq_state_e state_q, state_d;
    logic       mode_q, mode_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic [KW-1:0] k_q, k_d;
    logic [LW-1:0] len_q, len_d;

    logic          load;
    logic [KW-1:0] load_k;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        last_d  = last_q;
        k_d     = k_q;
        len_d   = len_q;
        load    = 1'b0;
        load_k  = k_q;

        unique case (state_q)
            StIdle: begin
                // abort beats a simultaneous start
                if (start_i && !abort_i) begin
                    mode_d  = mode_i;
                    load    = 1'b1;
                    load_k  = (mode_i == NTT_INV) ? KW'(Half - 1) : KW'(1);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StIdle;
                end else if (valid_q && tw_ready_i && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StFin;
                end else if (!valid_q || tw_ready_i) begin
                    // last_q is clear here, so k never steps past the end of the walk
                    load   = 1'b1;
                    load_k = (mode_q == NTT_INV) ? (k_q - KW'(1)) : (k_q + KW'(1));
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            valid_d = 1'b1;
            k_d     = load_k;
            len_d   = LW'(LOG_N - 1 - flog2(32'(load_k)));
            last_d  = (mode_d == NTT_INV) ? (load_k == KW'(1)) : (load_k == KW'(Half - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= NTT_FWD;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            k_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            k_q     <= k_d;
            len_q   <= len_d;
        end
    end

    // The ROM read register is the zeta field of the token register.
    ntt_tw_rom #(
        .Q     (Q),
        .QW    (QW),
        .LOG_N (LOG_N),
        .ROOT  (ROOT)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en_i   (load),
        .addr_i (load_k),
        .data_o (tw_zeta_o)
    );

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StFin);
    assign tw_valid_o    = valid_q;
    assign tw_k_o        = k_q;
    assign tw_len_log2_o = len_q;
    assign tw_last_o     = last_q;

endmodule
